// File: rtl/writeback_queue_if.sv
// writeback_queue_if: producer, retire-hold, scoreboard query and register_bank write signals
interface writeback_queue_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 4,
    parameter int DEPTH  = 4
);
    logic                       in_valid;
    logic                       in_ready;
    logic [ADDR_W-1:0]          in_addr;
    logic [DATA_W-1:0]          in_data;
    logic                       hold;
    logic                       flush;
    logic [ADDR_W-1:0]          q_ra;
    logic [ADDR_W-1:0]          q_rb;
    logic                       busy_a;
    logic                       busy_b;
    logic [$clog2(DEPTH+1)-1:0] count;
    logic [ADDR_W-1:0]          wc;
    logic [DATA_W-1:0]          wpc;
    logic                       w_rb;
    modport master (
        output in_valid, in_addr, in_data, hold, flush, q_ra, q_rb,
        input  in_ready, busy_a, busy_b, count, wc, wpc, w_rb
    );
    modport slave (
        input  in_valid, in_addr, in_data, hold, flush, q_ra, q_rb,
        output in_ready, busy_a, busy_b, count, wc, wpc, w_rb
    );
endinterface

// File: rtl/writeback_queue.sv
// writeback_queue: in-order write FIFO feeding register_bank with a pending-write scoreboard
module writeback_queue #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 4,
    parameter int DEPTH  = 4
) (
    input logic              clk,
    input logic              rst,
    writeback_queue_if.slave bus
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    logic [ADDR_W-1:0] mem_addr [DEPTH];
    logic [DATA_W-1:0] mem_data [DEPTH];
    logic [DEPTH-1:0]  vld;
    logic [PW-1:0]     wr_ptr;
    logic [PW-1:0]     rd_ptr;
    logic [CW-1:0]     cnt;
    logic              push;
    logic              pop;
    logic              hit_a;
    logic              hit_b;

    assign bus.in_ready = cnt < CW'(DEPTH);
    assign bus.count    = cnt;
    assign push         = bus.in_valid & bus.in_ready & ~bus.flush;
    assign pop          = (cnt != '0) & ~bus.hold & ~bus.flush;
    assign bus.busy_a   = hit_a | (bus.w_rb & (bus.wc == bus.q_ra));
    assign bus.busy_b   = hit_b | (bus.w_rb & (bus.wc == bus.q_rb));

    // scan queued entries for a pending write to either fetch-stage register
    always_comb begin
        hit_a = 1'b0;
        hit_b = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            hit_a = hit_a | (vld[i] & (mem_addr[i] == bus.q_ra));
            hit_b = hit_b | (vld[i] & (mem_addr[i] == bus.q_rb));
        end
    end

    // queue storage, pointers and the registered retire port; flush drops queued entries only
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            cnt      <= '0;
            vld      <= '0;
            bus.w_rb <= 1'b0;
            bus.wc   <= '0;
            bus.wpc  <= '0;
        end else if (bus.flush) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            cnt      <= '0;
            vld      <= '0;
            bus.w_rb <= 1'b0;
        end else begin
            if (push) begin
                mem_addr[wr_ptr] <= bus.in_addr;
                mem_data[wr_ptr] <= bus.in_data;
                vld[wr_ptr]      <= 1'b1;
                wr_ptr           <= wr_ptr + 1'b1;
            end
            if (pop) begin
                bus.wc      <= mem_addr[rd_ptr];
                bus.wpc     <= mem_data[rd_ptr];
                vld[rd_ptr] <= 1'b0;
                rd_ptr      <= rd_ptr + 1'b1;
            end
            bus.w_rb <= pop;
            cnt      <= cnt + CW'(push) - CW'(pop);
        end
    end
endmodule

// File: tb/tb_writeback_queue.sv
// tb_writeback_queue: directed stimulus with a retire-order scoreboard for writeback_queue
module tb_writeback_queue;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   total = 0;
    int   bad = 0;
    int   npulse = 0;
    logic [35:0] exp_q [$];
    logic [31:0] vec [16];
    logic [31:0] rf [16];
    int   base;

    writeback_queue_if #(.DATA_W(32), .ADDR_W(4), .DEPTH(4)) bus ();

    writeback_queue #(.DATA_W(32), .ADDR_W(4), .DEPTH(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s got=%h want=%h", name, act, req);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [3:0] a, input logic [31:0] d, input bit rec);
        bus.in_valid = 1'b1;
        bus.in_addr  = a;
        bus.in_data  = d;
        if (rec) exp_q.push_back({a, d});
        step();
        bus.in_valid = 1'b0;
    endtask

    // register_bank stand-in so retired values can be read back by index
    always @(posedge clk) if (bus.w_rb) rf[bus.wc] <= bus.wpc;

    // monitor: every write pulse must match the oldest expected entry
    always @(negedge clk) begin
        if (!rst && bus.w_rb) begin
            npulse++;
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_write got wc=%0d wpc=%h want=none", bus.wc, bus.wpc);
            end else begin
                logic [35:0] e;
                e = exp_q.pop_front();
                chk("retire_wc", 32'(bus.wc), 32'(e[35:32]));
                chk("retire_wpc", bus.wpc, e[31:0]);
            end
        end
    end

    initial begin
        bus.in_valid = 1'b0;
        bus.in_addr  = '0;
        bus.in_data  = '0;
        bus.hold     = 1'b0;
        bus.flush    = 1'b0;
        bus.q_ra     = 4'd0;
        bus.q_rb     = 4'd1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        chk("rst_w_rb", 32'(bus.w_rb), 0);
        chk("rst_wc", 32'(bus.wc), 0);
        chk("rst_wpc", bus.wpc, 0);
        chk("rst_count", 32'(bus.count), 0);
        chk("rst_in_ready", 32'(bus.in_ready), 1);
        chk("rst_busy_a", 32'(bus.busy_a), 0);
        chk("rst_busy_b", 32'(bus.busy_b), 0);

        push(4'd3, 32'hDEADBEEF, 1'b1);
        chk("single_lat_w_rb", 32'(bus.w_rb), 0);
        step();
        chk("single_w_rb", 32'(bus.w_rb), 1);
        chk("single_wc", 32'(bus.wc), 3);
        chk("single_wpc", bus.wpc, 32'hDEADBEEF);
        step();
        chk("single_w_rb_off", 32'(bus.w_rb), 0);

        base = npulse;
        for (int i = 0; i < 16; i++) vec[i] = $urandom;
        for (int i = 0; i < 16; i++) begin
            chk("stream_in_ready", 32'(bus.in_ready), 1);
            push(4'(i), vec[i], 1'b1);
        end
        repeat (3) step();
        chk("stream_pulses", 32'(npulse - base), 16);
        for (int i = 0; i < 16; i++) begin
            chk("readback_pra", rf[i], vec[i]);
            chk("readback_prb", rf[(i + 1) % 16], vec[(i + 1) % 16]);
        end

        base = npulse;
        bus.hold = 1'b1;
        for (int i = 1; i <= 4; i++) push(4'(i), 32'h100 + 32'(i), 1'b1);
        chk("full_count", 32'(bus.count), 4);
        chk("full_in_ready", 32'(bus.in_ready), 0);
        push(4'd9, 32'hBAD0_0005, 1'b0);
        chk("full_reject_count", 32'(bus.count), 4);
        bus.hold = 1'b0;
        repeat (4) step();
        chk("full_drain_w_rb", 32'(bus.w_rb), 1);
        step();
        chk("full_done_w_rb", 32'(bus.w_rb), 0);
        chk("full_pulses", 32'(npulse - base), 4);
        chk("full_exp_empty", 32'(exp_q.size()), 0);

        bus.hold = 1'b1;
        push(4'd5, 32'h5555_0005, 1'b1);
        bus.q_ra = 4'd5;
        bus.q_rb = 4'd6;
        #1;
        chk("sb_busy_a_queued", 32'(bus.busy_a), 1);
        chk("sb_busy_b_other", 32'(bus.busy_b), 0);
        bus.hold = 1'b0;
        step();
        chk("sb_w_rb", 32'(bus.w_rb), 1);
        chk("sb_count_zero", 32'(bus.count), 0);
        chk("sb_busy_a_retiring", 32'(bus.busy_a), 1);
        step();
        chk("sb_busy_a_done", 32'(bus.busy_a), 0);

        base = npulse;
        bus.hold = 1'b1;
        for (int i = 0; i < 3; i++) push(4'(7 + i), 32'h7000 + 32'(i), 1'b0);
        chk("flush_setup_count", 32'(bus.count), 3);
        bus.flush = 1'b1;
        bus.in_valid = 1'b1;
        bus.in_addr = 4'd10;
        bus.in_data = 32'hF1F1F1F1;
        step();
        bus.flush = 1'b0;
        bus.in_valid = 1'b0;
        bus.hold = 1'b0;
        chk("flush_count", 32'(bus.count), 0);
        chk("flush_w_rb", 32'(bus.w_rb), 0);
        repeat (3) step();
        chk("flush_no_pulse", 32'(npulse - base), 0);
        chk("flush_count_after", 32'(bus.count), 0);

        base = npulse;
        bus.hold = 1'b1;
        for (int i = 0; i < 3; i++) push(4'(11 + i), 32'hB000 + 32'(i), 1'b0);
        chk("rst_setup_count", 32'(bus.count), 3);
        rst = 1'b1;
        bus.in_valid = 1'b1;
        bus.in_addr = 4'd14;
        bus.in_data = 32'hE1E1E1E1;
        step();
        rst = 1'b0;
        bus.in_valid = 1'b0;
        bus.hold = 1'b0;
        chk("midrst_count", 32'(bus.count), 0);
        chk("midrst_w_rb", 32'(bus.w_rb), 0);
        repeat (3) step();
        chk("midrst_no_pulse", 32'(npulse - base), 0);
        chk("midrst_count_after", 32'(bus.count), 0);
        chk("final_exp_empty", 32'(exp_q.size()), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
